// File: rtl/player_hit_handler.sv
// Player hit handler: detects enemy-missile collisions with the player, requests
// missile removal, tracks lives and sequences ALIVE/EXPLODE/INVULN/GAME_OVER per frame.
module player_hit_handler #(
  parameter int LIVES_INIT     = 3,
  parameter int PLAYER_Y       = 440,
  parameter int PLAYER_W       = 32,
  parameter int PLAYER_H       = 16,
  parameter int MISSILE_W      = 2,
  parameter int MISSILE_H      = 8,
  parameter int EXPLODE_FRAMES = 45,
  parameter int INVULN_FRAMES  = 90,
  parameter int BLINK_SHIFT    = 3
) (
  input  logic       vsync,
  input  logic       reset_n,
  input  logic [3:0] state,
  input  logic       game_start,
  input  logic [9:0] playerX,
  input  logic       missile_exists,
  input  logic [9:0] missileX,
  input  logic [9:0] missileY,
  output logic       missile_clear,
  output logic [1:0] lives,
  output logic       player_visible,
  output logic       player_exploding,
  output logic       game_over
);

  localparam int CNT_MAX = (EXPLODE_FRAMES > INVULN_FRAMES) ? EXPLODE_FRAMES : INVULN_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] EXP_LAST = CNT_W'(EXPLODE_FRAMES - 1);
  localparam logic [CNT_W-1:0] INV_LAST = CNT_W'(INVULN_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
  localparam logic [1:0]       LIVES_L  = 2'(LIVES_INIT);
  localparam logic [10:0]      PY       = 11'(PLAYER_Y);
  localparam logic [10:0]      PW       = 11'(PLAYER_W);
  localparam logic [10:0]      PH       = 11'(PLAYER_H);
  localparam logic [10:0]      MW       = 11'(MISSILE_W);
  localparam logic [10:0]      MH       = 11'(MISSILE_H);

  typedef enum logic [1:0] {
    ST_ALIVE     = 2'd0,
    ST_EXPLODE   = 2'd1,
    ST_INVULN    = 2'd2,
    ST_GAME_OVER = 2'd3
  } fsm_t;

  fsm_t             fsm_q, fsm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       lives_q, lives_d;
  logic             clear_q, clear_d;
  logic             visible_q, visible_d;
  logic             exploding_q, exploding_d;
  logic             game_over_q, game_over_d;

  logic [10:0] px_e, mx_e, my_e;
  logic        hit_s;
  logic        playing_s;

  assign playing_s = (state == 4'd1);
  assign px_e      = {1'b0, playerX};
  assign mx_e      = {1'b0, missileX};
  assign my_e      = {1'b0, missileY};

  // Strict-overlap test in 11-bit arithmetic so no sum can wrap
  assign hit_s = missile_exists
               && ((mx_e + MW) > px_e) && (mx_e < (px_e + PW))
               && ((my_e + MH) > PY)   && (my_e < (PY + PH));

  // State and output registers
  always_ff @(posedge vsync or negedge reset_n) begin
    if (!reset_n) begin
      fsm_q       <= ST_ALIVE;
      cnt_q       <= '0;
      lives_q     <= LIVES_L;
      clear_q     <= 1'b0;
      visible_q   <= 1'b1;
      exploding_q <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      fsm_q       <= fsm_d;
      cnt_q       <= cnt_d;
      lives_q     <= lives_d;
      clear_q     <= clear_d;
      visible_q   <= visible_d;
      exploding_q <= exploding_d;
      game_over_q <= game_over_d;
    end
  end

  // Next state, frame counter, lives and clear request
  always_comb begin
    fsm_d   = fsm_q;
    cnt_d   = cnt_q;
    lives_d = lives_q;
    clear_d = 1'b0;
    if (game_start) begin
      fsm_d   = ST_ALIVE;
      cnt_d   = '0;
      lives_d = LIVES_L;
    end else if (playing_s) begin
      case (fsm_q)
        ST_ALIVE: begin
          if (hit_s && (lives_q != 2'd0)) begin
            clear_d = 1'b1;
            lives_d = lives_q - 2'd1;
            cnt_d   = '0;
            if (lives_q == 2'd1) begin
              fsm_d = ST_GAME_OVER;
            end else begin
              fsm_d = ST_EXPLODE;
            end
          end else begin
            fsm_d = ST_ALIVE;
          end
        end
        ST_EXPLODE: begin
          if (cnt_q == EXP_LAST) begin
            fsm_d = ST_INVULN;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_INVULN: begin
          if (cnt_q == INV_LAST) begin
            fsm_d = ST_ALIVE;
            cnt_d = '0;
          end else begin
            cnt_d = cnt_q + CNT_ONE;
          end
        end
        ST_GAME_OVER: fsm_d = ST_GAME_OVER;
        default: begin
          fsm_d = ST_ALIVE;
          cnt_d = '0;
        end
      endcase
    end else begin
      clear_d = 1'b0;
    end
  end

  // Sprite flags derive from the upcoming state so they register alongside it
  always_comb begin
    visible_d   = 1'b0;
    exploding_d = 1'b0;
    game_over_d = 1'b0;
    case (fsm_d)
      ST_ALIVE:     visible_d = 1'b1;
      ST_EXPLODE:   exploding_d = 1'b1;
      ST_INVULN:    visible_d = ~cnt_d[BLINK_SHIFT];
      ST_GAME_OVER: begin
        exploding_d = 1'b1;
        game_over_d = 1'b1;
      end
      default:      visible_d = 1'b1;
    endcase
  end

  assign missile_clear    = clear_q;
  assign lives            = lives_q;
  assign player_visible   = visible_q;
  assign player_exploding = exploding_q;
  assign game_over        = game_over_q;

endmodule

// File: tb/tb_player_hit_handler.sv
// Directed bench for player_hit_handler: collision edges, explode/invuln timing,
// pause freeze, game over, game_start priority and asynchronous reset.
module tb_player_hit_handler;

  logic       vsync;
  logic       reset_n;
  logic [3:0] state;
  logic       game_start;
  logic [9:0] playerX;
  logic       missile_exists;
  logic [9:0] missileX;
  logic [9:0] missileY;
  logic       missile_clear;
  logic [1:0] lives;
  logic       player_visible;
  logic       player_exploding;
  logic       game_over;

  int checks = 0;
  int errors = 0;

  player_hit_handler dut (
    .vsync            (vsync),
    .reset_n          (reset_n),
    .state            (state),
    .game_start       (game_start),
    .playerX          (playerX),
    .missile_exists   (missile_exists),
    .missileX         (missileX),
    .missileY         (missileY),
    .missile_clear    (missile_clear),
    .lives            (lives),
    .player_visible   (player_visible),
    .player_exploding (player_exploding),
    .game_over        (game_over)
  );

  initial vsync = 1'b0;
  always #5 vsync = ~vsync;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge vsync);
    #1;
  endtask

  // Collision table: missile X, missile Y, exists, game state, expected hit
  int tx  [10] = '{298, 299, 310, 310, 332, 331, 310, 310, 310, 310};
  int ty  [10] = '{440, 440, 432, 433, 440, 440, 456, 455, 440, 440};
  int tex [10] = '{1,   1,   1,   1,   1,   1,   1,   1,   0,   1};
  int tst [10] = '{1,   1,   1,   1,   1,   1,   1,   1,   1,   2};
  int thit[10] = '{0,   1,   0,   1,   0,   1,   0,   1,   0,   0};

  initial begin
    reset_n        = 1'b1;
    state          = 4'd0;
    game_start     = 1'b0;
    playerX        = 10'd300;
    missile_exists = 1'b0;
    missileX       = 10'd0;
    missileY       = 10'd0;
    #2 reset_n = 1'b0;
    #2;
    check("rst_lives", 32'(lives), 32'd3);
    check("rst_clear", 32'(missile_clear), 32'd0);
    check("rst_visible", 32'(player_visible), 32'd1);
    check("rst_exploding", 32'(player_exploding), 32'd0);
    check("rst_game_over", 32'(game_over), 32'd0);
    #3 reset_n = 1'b1;

    // Collision boundaries, recovering with game_start after each entry
    for (int i = 0; i < 10; i++) begin
      missileX       = 10'(tx[i]);
      missileY       = 10'(ty[i]);
      missile_exists = 1'(tex[i]);
      state          = 4'(tst[i]);
      tick();
      check($sformatf("edge%0d_clear", i), 32'(missile_clear), 32'(thit[i]));
      check($sformatf("edge%0d_lives", i), 32'(lives), (thit[i] != 0) ? 32'd2 : 32'd3);
      check($sformatf("edge%0d_expl", i), 32'(player_exploding), 32'(thit[i]));
      missile_exists = 1'b0;
      state          = 4'd1;
      game_start     = 1'b1;
      tick();
      game_start = 1'b0;
      check($sformatf("edge%0d_gs_lives", i), 32'(lives), 32'd3);
      check($sformatf("edge%0d_gs_vis", i), 32'(player_visible), 32'd1);
      check($sformatf("edge%0d_gs_clear", i), 32'(missile_clear), 32'd0);
    end

    // First hit, then hold the missile on the player through EXPLODE and INVULN
    missileX       = 10'd310;
    missileY       = 10'd440;
    missile_exists = 1'b1;
    state          = 4'd1;
    tick();
    check("hit_clear", 32'(missile_clear), 32'd1);
    check("hit_lives", 32'(lives), 32'd2);
    check("hit_expl", 32'(player_exploding), 32'd1);
    check("hit_vis", 32'(player_visible), 32'd0);
    for (int f = 1; f < 135; f++) begin
      tick();
      check($sformatf("hold%0d_clear", f), 32'(missile_clear), 32'd0);
      check($sformatf("hold%0d_lives", f), 32'(lives), 32'd2);
      check($sformatf("hold%0d_expl", f), 32'(player_exploding), (f < 45) ? 32'd1 : 32'd0);
      check($sformatf("hold%0d_vis", f), 32'(player_visible),
            (f < 45) ? 32'd0 : ((((f - 45) >> 3) & 1) != 0 ? 32'd0 : 32'd1));
    end
    tick();
    check("alive_vis", 32'(player_visible), 32'd1);
    check("alive_clear", 32'(missile_clear), 32'd0);
    check("alive_lives", 32'(lives), 32'd2);
    tick();
    check("hit2_clear", 32'(missile_clear), 32'd1);
    check("hit2_lives", 32'(lives), 32'd1);
    check("hit2_expl", 32'(player_exploding), 32'd1);

    // Pause mid-EXPLODE at counter 20; remaining 25 frames run after resume
    for (int f = 0; f < 20; f++) tick();
    state = 4'd2;
    for (int f = 0; f < 50; f++) begin
      tick();
      check($sformatf("pause%0d_expl", f), 32'(player_exploding), 32'd1);
      check($sformatf("pause%0d_clear", f), 32'(missile_clear), 32'd0);
    end
    state = 4'd1;
    for (int f = 0; f < 24; f++) tick();
    check("resume24_expl", 32'(player_exploding), 32'd1);
    tick();
    check("resume25_expl", 32'(player_exploding), 32'd0);
    check("resume25_vis", 32'(player_visible), 32'd1);

    // Finish INVULN with the missile still overlapping, then the final hit
    for (int f = 0; f < 89; f++) begin
      tick();
      check($sformatf("inv%0d_clear", f), 32'(missile_clear), 32'd0);
    end
    check("inv_end_lives", 32'(lives), 32'd1);
    tick();
    check("alive2_vis", 32'(player_visible), 32'd1);
    check("alive2_clear", 32'(missile_clear), 32'd0);
    tick();
    check("last_clear", 32'(missile_clear), 32'd1);
    check("last_lives", 32'(lives), 32'd0);
    check("last_go", 32'(game_over), 32'd1);
    check("last_expl", 32'(player_exploding), 32'd1);
    check("last_vis", 32'(player_visible), 32'd0);
    for (int f = 0; f < 5; f++) begin
      tick();
      check($sformatf("go%0d_clear", f), 32'(missile_clear), 32'd0);
      check($sformatf("go%0d_lives", f), 32'(lives), 32'd0);
      check($sformatf("go%0d_go", f), 32'(game_over), 32'd1);
    end
    missile_exists = 1'b0;
    game_start     = 1'b1;
    tick();
    game_start = 1'b0;
    check("restart_lives", 32'(lives), 32'd3);
    check("restart_go", 32'(game_over), 32'd0);
    check("restart_vis", 32'(player_visible), 32'd1);
    check("restart_expl", 32'(player_exploding), 32'd0);

    // Reach INVULN counter 10 (sprite hidden), then reset asynchronously
    missile_exists = 1'b1;
    tick();
    check("r_hit_lives", 32'(lives), 32'd2);
    for (int f = 0; f < 55; f++) tick();
    check("r_inv_vis", 32'(player_visible), 32'd0);
    check("r_inv_expl", 32'(player_exploding), 32'd0);
    #2 reset_n = 1'b0;
    #1;
    check("arst_lives", 32'(lives), 32'd3);
    check("arst_vis", 32'(player_visible), 32'd1);
    check("arst_expl", 32'(player_exploding), 32'd0);
    check("arst_clear", 32'(missile_clear), 32'd0);
    check("arst_go", 32'(game_over), 32'd0);
    tick();
    reset_n = 1'b1;

    // game_start beats a simultaneous hit
    game_start = 1'b1;
    tick();
    game_start = 1'b0;
    check("gs_hit_lives", 32'(lives), 32'd3);
    check("gs_hit_clear", 32'(missile_clear), 32'd0);
    check("gs_hit_expl", 32'(player_exploding), 32'd0);
    check("gs_hit_vis", 32'(player_visible), 32'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
